// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - fetch PC owner issuing in-order instruction reads into a flushable queue
// Responses for requests issued before a redirect are counted in discard and dropped on return.
module instruction_fetch_queue #(
  parameter int PCBITWIDTH = 16,
  parameter int QUEUEDEPTH = 4,
  parameter logic [PCBITWIDTH-1:0] RESETVECTOR = '0
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  output logic                  InstReqValid,
  input  logic                  InstReqReady,
  output logic [PCBITWIDTH-1:0] InstReqAddr,
  input  logic                  InstRespValid,
  input  logic [15:0]           InstResp,
  output logic                  FetchedInstructionValid,
  output logic [15:0]           FetchedInstruction,
  output logic [PCBITWIDTH-1:0] FetchedPC,
  input  logic                  DecoderReady,
  input  logic                  RedirectValid,
  input  logic [PCBITWIDTH-1:0] RedirectAddr
);
  localparam int AW = $clog2(QUEUEDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(QUEUEDEPTH);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                  state;
  logic [PCBITWIDTH-1:0]   pc;
  logic [CW-1:0]           outstanding, discard, occupancy;
  logic [15:0]             inst_q [QUEUEDEPTH];
  logic [PCBITWIDTH-1:0]   pc_q   [QUEUEDEPTH];
  logic [PCBITWIDTH-1:0]   addr_q [QUEUEDEPTH];
  logic [AW-1:0]           q_wr, q_rd, a_wr, a_rd;

  logic          redirect, credit_ok, req_valid, accept;
  logic          resp, drop, keep, push, fetched_valid, pop;
  logic [CW-1:0] discard_redir, discard_next;

  // Credit covers only new-path work: in-flight requests plus filled entries.
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH;
  assign redirect      = clk_en & RedirectValid;
  assign req_valid     = clk_en & (state != BOOT) & ~RedirectValid & credit_ok;
  assign accept        = req_valid & InstReqReady;
  assign resp          = clk_en & InstRespValid;
  assign drop          = resp & (discard != '0);
  assign keep          = resp & (discard == '0);
  assign push          = keep & ~RedirectValid;
  assign fetched_valid = (occupancy != '0) & ~RedirectValid & clk_en;
  assign pop           = fetched_valid & DecoderReady;

  // Any response this cycle retires either an old-path or a new-path request, both now stale.
  assign discard_redir = discard + outstanding + CW'(accept) - CW'(resp);
  assign discard_next  = redirect ? discard_redir : discard - CW'(drop);

  assign InstReqValid            = req_valid;
  assign InstReqAddr             = req_valid ? pc : '0;
  assign FetchedInstructionValid = fetched_valid;
  assign FetchedInstruction      = inst_q[q_rd];
  assign FetchedPC               = pc_q[q_rd];

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state       <= BOOT;
      pc          <= RESETVECTOR;
      outstanding <= '0;
      discard     <= '0;
      occupancy   <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      a_wr        <= '0;
      a_rd        <= '0;
      for (int i = 0; i < QUEUEDEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        addr_q[i] <= '0;
      end
    end else if (clk_en) begin
      discard <= discard_next;
      if (redirect) begin
        state       <= (discard_redir != '0) ? FLUSH : RUN;
        pc          <= RedirectAddr;
        outstanding <= '0;
        occupancy   <= '0;
        q_wr        <= '0;
        q_rd        <= '0;
        a_wr        <= '0;
        a_rd        <= '0;
      end else begin
        if (state == BOOT)
          state <= RUN;
        else if (state == FLUSH && discard_next == '0)
          state <= RUN;
        outstanding <= outstanding + CW'(accept) - CW'(keep);
        occupancy   <= occupancy + CW'(push) - CW'(pop);
        if (accept) begin
          pc           <= pc + PCBITWIDTH'(1);
          addr_q[a_wr] <= pc;
          a_wr         <= a_wr + AW'(1);
        end
        if (push) begin
          inst_q[q_wr] <= InstResp;
          pc_q[q_wr]   <= addr_q[a_rd];
          q_wr         <= q_wr + AW'(1);
          a_rd         <= a_rd + AW'(1);
        end
        if (pop)
          q_rd <= q_rd + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - scoreboard bench for instruction_fetch_queue with a variable-latency memory
module tb_instruction_fetch_queue;
  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        InstReqValid, InstReqReady;
  logic [15:0] InstReqAddr;
  logic        InstRespValid;
  logic [15:0] InstResp;
  logic        FetchedInstructionValid;
  logic [15:0] FetchedInstruction, FetchedPC;
  logic        DecoderReady, RedirectValid;
  logic [15:0] RedirectAddr;

  always #5 clk = ~clk;

  instruction_fetch_queue dut (
    .clk                    (clk),
    .async_rst_n            (async_rst_n),
    .clk_en                 (clk_en),
    .InstReqValid           (InstReqValid),
    .InstReqReady           (InstReqReady),
    .InstReqAddr            (InstReqAddr),
    .InstRespValid          (InstRespValid),
    .InstResp               (InstResp),
    .FetchedInstructionValid(FetchedInstructionValid),
    .FetchedInstruction     (FetchedInstruction),
    .FetchedPC              (FetchedPC),
    .DecoderReady           (DecoderReady),
    .RedirectValid          (RedirectValid),
    .RedirectAddr           (RedirectAddr)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] model_pc;
  int          cyc, lat, n_tests, n_fail, n_req, n_pop, first_req_cyc;
  logic        want_first, saw_wrap;
  logic [15:0] first_pc, prev_pop_pc, last_fpc, last_finst;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: present memory response, sample at negedge, update models, advance.
  task automatic cycle();
    logic [15:0] e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      InstRespValid = 1'b1;
      InstResp      = mem_f(mem_q[0].addr);
    end else begin
      InstRespValid = 1'b0;
      InstResp      = '0;
    end
    @(negedge clk);
    last_fpc   = FetchedPC;
    last_finst = FetchedInstruction;
    if (!clk_en) begin
      check("stall_req", InstReqValid, 0);
      check("stall_pop", FetchedInstructionValid, 0);
    end else if (RedirectValid) begin
      check("redir_req", InstReqValid, 0);
      check("redir_pop", FetchedInstructionValid, 0);
      exp_q.delete();
      model_pc   = RedirectAddr;
      want_first = 1'b1;
      first_pc   = 16'hDEAD;
    end else begin
      if (InstReqValid) begin
        check("req_addr", InstReqAddr, model_pc);
        if (InstReqReady) begin
          mem_q.push_back('{InstReqAddr, cyc + lat});
          exp_q.push_back(model_pc);
          model_pc = model_pc + 16'd1;
          n_req++;
          if (first_req_cyc < 0) first_req_cyc = cyc;
        end
      end
      if (FetchedInstructionValid && DecoderReady) begin
        if (exp_q.size() == 0) begin
          check("pop_on_empty_model", FetchedInstructionValid, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", FetchedPC, e);
          check("pop_inst", FetchedInstruction, mem_f(e));
          if (want_first) begin
            first_pc   = FetchedPC;
            want_first = 1'b0;
          end
          if (FetchedPC == 16'h0000 && prev_pop_pc == 16'hFFFF) saw_wrap = 1'b1;
          prev_pop_pc = FetchedPC;
          n_pop++;
        end
      end
    end
    if (clk_en && InstRespValid) void'(mem_q.pop_front());
    @(posedge clk);
    if (clk_en) cyc++;
    #1;
  endtask

  task automatic drain(input string tag);
    InstReqReady  = 1'b0;
    DecoderReady  = 1'b1;
    RedirectValid = 1'b0;
    for (int i = 0; i < 60 && (exp_q.size() > 0 || mem_q.size() > 0); i++) cycle();
    check({tag, "_drained"}, exp_q.size() + mem_q.size(), 0);
    cycle();
    check({tag, "_empty"}, FetchedInstructionValid, 0);
  endtask

  task automatic redirect_to(input logic [15:0] a);
    RedirectValid = 1'b1;
    RedirectAddr  = a;
    cycle();
    RedirectValid = 1'b0;
  endtask

  initial begin
    int base, pbase;
    logic [15:0] h_pc, h_in;
    InstReqReady  = 1'b0;
    InstRespValid = 1'b0;
    InstResp      = '0;
    DecoderReady  = 1'b0;
    RedirectValid = 1'b0;
    RedirectAddr  = '0;
    lat = 1; cyc = 0; n_tests = 0; n_fail = 0; n_req = 0; n_pop = 0;
    first_req_cyc = -1; model_pc = 16'h0000; saw_wrap = 1'b0;
    want_first = 1'b1; first_pc = 16'hDEAD; prev_pop_pc = 16'h1234;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", InstReqValid, 0);
    check("rst_req_addr", InstReqAddr, 0);
    check("rst_out_valid", FetchedInstructionValid, 0);
    check("rst_out_pc", FetchedPC, 0);
    check("rst_out_inst", FetchedInstruction, 0);
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;

    // 1: stream from reset vector with 1-cycle memory
    InstReqReady = 1'b1;
    DecoderReady = 1'b1;
    repeat (12) cycle();
    check("t1_first_req_cycle", first_req_cyc, 1);
    check("t1_first_pc", first_pc, 16'h0000);
    drain("t1");

    // 2: decoder backpressure fills exactly QUEUEDEPTH credits
    base  = n_req;
    pbase = n_pop;
    DecoderReady = 1'b0;
    InstReqReady = 1'b1;
    repeat (12) cycle();
    check("t2_req_count", n_req - base, 4);
    check("t2_req_dropped", InstReqValid, 0);
    check("t2_no_pop", n_pop - pbase, 0);
    DecoderReady = 1'b1;
    repeat (10) cycle();
    check("t2_resumed", (n_req - base) > 4, 1);
    drain("t2");

    // 3: three in flight on 3-cycle memory, then redirect
    lat  = 3;
    base = n_req;
    InstReqReady = 1'b1;
    DecoderReady = 1'b1;
    repeat (3) cycle();
    check("t3_inflight", n_req - base, 3);
    redirect_to(16'h0100);
    repeat (12) cycle();
    drain("t3");
    check("t3_first_pc", first_pc, 16'h0100);

    // 4: redirect while requests are accepted and responses return every cycle
    for (int off = 0; off < 4; off++) begin
      lat = 2;
      InstReqReady = 1'b1;
      DecoderReady = 1'b1;
      repeat (4 + off) cycle();
      redirect_to(16'h0200 + 16'(off * 16));
      repeat (8) cycle();
      drain("t4");
      check("t4_first_pc", first_pc, 16'h0200 + 16'(off * 16));
    end

    // 5: two redirects two cycles apart
    lat = 3;
    InstReqReady = 1'b1;
    DecoderReady = 1'b1;
    repeat (4) cycle();
    redirect_to(16'h0040);
    cycle();
    redirect_to(16'h0080);
    repeat (10) cycle();
    drain("t5");
    check("t5_first_pc", first_pc, 16'h0080);
    check("t5_state_run", dut.state, 1);

    // 6: global stall mid-stream, then PC wrap
    lat = 1;
    InstReqReady = 1'b1;
    DecoderReady = 1'b1;
    redirect_to(16'hFFFD);
    repeat (3) cycle();
    clk_en = 1'b0;
    base  = n_req;
    pbase = n_pop;
    cycle();
    h_pc = last_fpc;
    h_in = last_finst;
    repeat (4) begin
      cycle();
      check("t6_head_pc_stable", last_fpc, h_pc);
      check("t6_head_inst_stable", last_finst, h_in);
    end
    check("t6_no_req", n_req - base, 0);
    check("t6_no_pop", n_pop - pbase, 0);
    clk_en = 1'b1;
    repeat (8) cycle();
    drain("t6");
    check("t6_first_pc", first_pc, 16'hFFFD);
    check("t6_wrap", saw_wrap, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
